// File: rtl/game_pkg.sv
// game_pkg: shared types and constants for the match-level game sequencer.
//   phase_t      - match phase encoding (also driven on the 2-bit phase port)
//   GM_*         - game_mode encodings
//   WIN_*        - winner encodings
//   KEYC_*       - default USB HID keycodes for the watched keys
package game_pkg;

  typedef enum logic [1:0] {
    TITLE     = 2'd0,
    FIGHT     = 2'd1,
    ROUND_END = 2'd2,
    MATCH_END = 2'd3
  } phase_t;

  localparam logic [2:0] GM_TITLE = 3'b000;
  localparam logic [2:0] GM_AI    = 3'b001;
  localparam logic [2:0] GM_2P    = 3'b010;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;

  localparam logic [7:0] KEYC_AI      = 8'h1E;  // '1'
  localparam logic [7:0] KEYC_2P      = 8'h1F;  // '2'
  localparam logic [7:0] KEYC_NEXT    = 8'h28;  // Enter
  localparam logic [7:0] KEYC_RESTART = 8'h15;  // 'R'

endpackage

// File: rtl/game_sequencer_key_edge.sv
// key_edge: press detector for one watched keycode.
//   Clk      - system clock
//   Reset    - synchronous active-high reset (clears match history)
//   keycodes - four keycode bytes {k3,k2,k1,k0}
//   hit      - high for the first cycle KEY appears in any byte
// Keycode 8'h00 means "no key" and is never treated as a match.
module key_edge
  import game_pkg::*;
#(
  parameter logic [7:0] KEY = KEYC_AI
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] keycodes,
  output logic        hit
);

  logic [3:0] lane_match;
  logic       match;
  logic       match_prev_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_match[gi] = (KEY != 8'h00) && (keycodes[gi*8 +: 8] == KEY);
    end
  endgenerate

  assign match = |lane_match;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      match_prev_reg <= 1'b0;
    end else begin
      match_prev_reg <= match;
    end
  end

  // A held key matches every cycle but only fires on the first one.
  assign hit = match & ~match_prev_reg;

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: match-level controller for the fighting game.
//   Clk         - system clock (MAX10_CLK1_50)
//   Reset       - synchronous active-high reset
//   frame_clk   - VGA_VS, sampled as data through a 2-FF synchronizer
//   keycodes    - four keycode bytes {k3,k2,k1,k0}
//   p1_lose     - player-1 health exhausted
//   p2_lose     - player-2 health exhausted
//   game_mode   - 000 title, 001 vs AI, 010 2P
//   phase       - TITLE / FIGHT / ROUND_END / MATCH_END
//   count       - frames elapsed in ROUND_END / MATCH_END
//   round_reset - one-cycle pulse re-arming players, health, sprite ROMs
//   p1_rounds   - round wins, player 1
//   p2_rounds   - round wins, player 2
//   winner      - 0 none, 1 P1, 2 P2 (valid in MATCH_END)
module game_sequencer
  import game_pkg::*;
#(
  parameter int         ROUNDS_TO_WIN    = 2,
  parameter int         ROUND_END_FRAMES = 50,
  parameter logic [7:0] KEY_AI           = KEYC_AI,
  parameter logic [7:0] KEY_2P           = KEYC_2P,
  parameter logic [7:0] KEY_NEXT         = KEYC_NEXT,
  parameter logic [7:0] KEY_RESTART      = KEYC_RESTART
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [31:0] keycodes,
  input  logic        p1_lose,
  input  logic        p2_lose,
  output logic [2:0]  game_mode,
  output logic [1:0]  phase,
  output logic [8:0]  count,
  output logic        round_reset,
  output logic [1:0]  p1_rounds,
  output logic [1:0]  p2_rounds,
  output logic [1:0]  winner
);

  localparam logic [1:0]  RTW       = 2'(ROUNDS_TO_WIN);
  localparam logic [8:0]  RE_FRAMES = 9'(ROUND_END_FRAMES);
  localparam logic [8:0]  COUNT_MAX = 9'd511;
  localparam logic [31:0] WATCH     = {KEY_RESTART, KEY_NEXT, KEY_2P, KEY_AI};

  // ---------------- key press detection ----------------
  logic [3:0] key_hits;  // {restart, next, 2p, ai}

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_key
      key_edge #(.KEY(WATCH[gi*8 +: 8])) u_key_edge (
        .Clk      (Clk),
        .Reset    (Reset),
        .keycodes (keycodes),
        .hit      (key_hits[gi])
      );
    end
  endgenerate

  logic hit_ai, hit_2p, hit_next, hit_restart;
  assign hit_ai      = key_hits[0];
  assign hit_2p      = key_hits[1];
  assign hit_next    = key_hits[2];
  assign hit_restart = key_hits[3];

  // ---------------- frame tick ----------------
  logic fs_meta_reg, fs_sync_reg, fs_prev_reg;
  logic frame_tick;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fs_meta_reg <= 1'b0;
      fs_sync_reg <= 1'b0;
      fs_prev_reg <= 1'b0;
    end else begin
      fs_meta_reg <= frame_clk;
      fs_sync_reg <= fs_meta_reg;
      fs_prev_reg <= fs_sync_reg;
    end
  end

  assign frame_tick = fs_sync_reg & ~fs_prev_reg;

  // ---------------- match FSM ----------------
  phase_t     phase_reg;
  logic [2:0] game_mode_reg;
  logic [8:0] count_reg;
  logic       round_reset_reg;
  logic [1:0] p1_rounds_reg, p2_rounds_reg, winner_reg;
  // Set on FIGHT entry; lose flags are ignored until the next frame tick so
  // that a flag still high from the previous round is not re-counted.
  logic       blank_reg;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      phase_reg       <= TITLE;
      game_mode_reg   <= GM_TITLE;
      count_reg       <= '0;
      round_reset_reg <= 1'b0;
      p1_rounds_reg   <= '0;
      p2_rounds_reg   <= '0;
      winner_reg      <= WIN_NONE;
      blank_reg       <= 1'b0;
    end else begin
      round_reset_reg <= 1'b0;
      if (hit_restart) begin
        phase_reg     <= TITLE;
        game_mode_reg <= GM_TITLE;
        count_reg     <= '0;
        p1_rounds_reg <= '0;
        p2_rounds_reg <= '0;
        winner_reg    <= WIN_NONE;
        blank_reg     <= 1'b0;
        // If the datapath was re-armed last cycle it is already clean, so the
        // pulse is dropped rather than stretched to two cycles.
        round_reset_reg <= ~round_reset_reg;
      end else begin
        case (phase_reg)
          TITLE: begin
            if (hit_ai || hit_2p) begin
              game_mode_reg   <= hit_ai ? GM_AI : GM_2P;
              phase_reg       <= FIGHT;
              count_reg       <= '0;
              blank_reg       <= 1'b1;
              round_reset_reg <= ~round_reset_reg;
            end
          end
          FIGHT: begin
            if (blank_reg) begin
              if (frame_tick) blank_reg <= 1'b0;
            end else if (p1_lose || p2_lose) begin
              if (p1_lose && !p2_lose && p2_rounds_reg != 2'd3)
                p2_rounds_reg <= p2_rounds_reg + 2'd1;
              if (p2_lose && !p1_lose && p1_rounds_reg != 2'd3)
                p1_rounds_reg <= p1_rounds_reg + 2'd1;
              phase_reg <= ROUND_END;
              count_reg <= '0;
            end
          end
          ROUND_END: begin
            if (count_reg == RE_FRAMES) begin
              if (p1_rounds_reg >= RTW || p2_rounds_reg >= RTW) begin
                phase_reg  <= MATCH_END;
                count_reg  <= '0;
                winner_reg <= (p1_rounds_reg >= RTW) ? WIN_P1 : WIN_P2;
              end else begin
                phase_reg       <= FIGHT;
                count_reg       <= '0;
                blank_reg       <= 1'b1;
                round_reset_reg <= ~round_reset_reg;
              end
            end else if (frame_tick) begin
              count_reg <= count_reg + 9'd1;
            end
          end
          MATCH_END: begin
            if (hit_next) begin
              phase_reg       <= TITLE;
              game_mode_reg   <= GM_TITLE;
              count_reg       <= '0;
              p1_rounds_reg   <= '0;
              p2_rounds_reg   <= '0;
              winner_reg      <= WIN_NONE;
              round_reset_reg <= ~round_reset_reg;
            end else if (frame_tick && count_reg != COUNT_MAX) begin
              count_reg <= count_reg + 9'd1;
            end
          end
          default: phase_reg <= TITLE;
        endcase
      end
    end
  end

  assign game_mode   = game_mode_reg;
  assign phase       = phase_reg;
  assign count       = count_reg;
  assign round_reset = round_reset_reg;
  assign p1_rounds   = p1_rounds_reg;
  assign p2_rounds   = p2_rounds_reg;
  assign winner      = winner_reg;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed-plus-random bench for game_sequencer with a
// phase-level reference model (expected phase/mode/scores/count per step).
module tb_game_sequencer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_clk;
  logic [31:0] keycodes;
  logic        p1_lose, p2_lose;
  logic [2:0]  game_mode;
  logic [1:0]  phase;
  logic [8:0]  count;
  logic        round_reset;
  logic [1:0]  p1_rounds, p2_rounds, winner;

  game_sequencer dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_clk   (frame_clk),
    .keycodes    (keycodes),
    .p1_lose     (p1_lose),
    .p2_lose     (p2_lose),
    .game_mode   (game_mode),
    .phase       (phase),
    .count       (count),
    .round_reset (round_reset),
    .p1_rounds   (p1_rounds),
    .p2_rounds   (p2_rounds),
    .winner      (winner)
  );

  always #10 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;
  int rr_total = 0;
  logic rr_prev = 1'b0;

  // Reference model state
  int m_phase, m_mode, m_p1, m_p2, m_win, m_count;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse counter plus the never-two-in-a-row rule
  always @(negedge Clk) begin
    if (!Reset) begin
      if (round_reset) rr_total++;
      n_checks++;
      assert (!(round_reset && rr_prev)) else begin
        n_fail++;
        $error("FAIL rr_consecutive: observed 2 expected 1");
      end
    end
    rr_prev = round_reset;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    check($sformatf("%s.phase", tag), int'(phase), m_phase);
    check($sformatf("%s.mode", tag), int'(game_mode), m_mode);
    check($sformatf("%s.p1", tag), int'(p1_rounds), m_p1);
    check($sformatf("%s.p2", tag), int'(p2_rounds), m_p2);
    check($sformatf("%s.win", tag), int'(winner), m_win);
    check($sformatf("%s.count", tag), int'(count), m_count);
  endtask

  // One VGA frame: rising edge on frame_clk, six clocks long
  task automatic frame();
    frame_clk = 1'b1;
    tick(3);
    frame_clk = 1'b0;
    tick(3);
  endtask

  // Model: a frame in a counting phase advances count with saturation
  task automatic model_frame();
    if (m_phase == 2 && m_count < 50) m_count++;
    else if (m_phase == 3 && m_count < 511) m_count++;
  endtask

  function automatic logic [31:0] key_word(input logic [7:0] key, input int lane);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) begin
      // Fillers 0x04..0x14 never collide with a watched key
      w[i*8 +: 8] = 8'($urandom_range(4, 20));
    end
    w[lane*8 +: 8] = key;
    return w;
  endfunction

  // Press a key, hold it, check the single resulting round_reset pulse
  task automatic press(input string tag, input logic [31:0] kw, input int hold);
    int rr0;
    rr0 = rr_total;
    keycodes = kw;
    tick(1);
    check_all(tag);
    check($sformatf("%s.rr_now", tag), int'(round_reset), 1);
    tick(hold);
    keycodes = 32'h0;
    tick(2);
    check($sformatf("%s.rr_pulses", tag), rr_total - rr0, 1);
  endtask

  // who: 1 = p1 loses, 2 = p2 loses, 3 = both lose (draw)
  task automatic play_round(input string tag, input int who);
    int rr0;
    frame();  // first frame after FIGHT entry ends the lose blanking window
    p1_lose = (who == 1 || who == 3);
    p2_lose = (who == 2 || who == 3);
    tick(1);
    if (who == 1 && m_p2 < 3) m_p2++;
    if (who == 2 && m_p1 < 3) m_p1++;
    m_phase = 2;
    m_count = 0;
    check_all($sformatf("%s.lose", tag));
    tick(1);
    p1_lose = 1'b0;
    p2_lose = 1'b0;
    rr0 = rr_total;
    for (int f = 1; f <= 50; f++) begin
      frame();
      if (f < 50) model_frame();
      if (f == 1 || f == 49) check_all($sformatf("%s.f%0d", tag, f));
    end
    // Hold time over: match decided or next round armed
    if (m_p1 >= 2 || m_p2 >= 2) begin
      m_phase = 3;
      m_count = 0;
      m_win = (m_p1 >= 2) ? 1 : 2;
      check($sformatf("%s.rr_none", tag), rr_total - rr0, 0);
    end else begin
      m_phase = 1;
      m_count = 0;
      check($sformatf("%s.rr_pulses", tag), rr_total - rr0, 1);
    end
    check_all($sformatf("%s.after", tag));
  endtask

  task automatic model_title();
    m_phase = 0; m_mode = 0; m_p1 = 0; m_p2 = 0; m_win = 0; m_count = 0;
  endtask

  initial begin
    Reset = 1'b1;
    frame_clk = 1'b0;
    keycodes = 32'h0;
    p1_lose = 1'b0;
    p2_lose = 1'b0;
    model_title();
    tick(5);
    check_all("reset");
    check("reset.rr", int'(round_reset), 0);
    Reset = 1'b0;
    tick(2);

    // Start vs AI, key held for 100 cycles
    m_phase = 1; m_mode = 1;
    press("start_ai", 32'h0000001E, 100);

    // Lose flag during the blanking window must be ignored
    p2_lose = 1'b1;
    tick(4);
    check_all("blanked");
    p2_lose = 1'b0;
    tick(1);

    play_round("r1_p2lose", 2);
    play_round("r2_draw", 3);
    play_round("r3_p2lose", 2);

    // MATCH_END count saturates at 511
    for (int f = 0; f < 515; f++) begin
      frame();
      model_frame();
      if (f == 9) check_all("me.f10");
    end
    check_all("me.sat");

    // Enter in byte k2 returns to title
    model_title();
    press("next", 32'h00280000, 5);

    // 2P match with random key lane, then restart during ROUND_END at count 20
    m_phase = 1; m_mode = 2;
    press("start_2p", key_word(8'h1F, $urandom_range(0, 3)), 3);
    frame();
    p1_lose = 1'b1;
    tick(1);
    p1_lose = 1'b0;
    m_p2 = 1; m_phase = 2; m_count = 0;
    check_all("2p.lose");
    for (int f = 0; f < 20; f++) begin
      frame();
      model_frame();
    end
    check_all("2p.c20");
    model_title();
    press("restart", 32'h00001500, 3);

    // AI match won by P2 over two rounds with a random key lane
    m_phase = 1; m_mode = 1;
    press("start_ai2", key_word(8'h1E, $urandom_range(0, 3)), 2);
    play_round("m3r1", 1);
    play_round("m3r2", 1);
    for (int f = 0; f < 300; f++) begin
      frame();
      model_frame();
    end
    check_all("m3.c300");

    // Synchronous reset mid-MATCH_END
    Reset = 1'b1;
    tick(1);
    model_title();
    check_all("mid_reset");
    check("mid_reset.rr", int'(round_reset), 0);
    Reset = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Match-level controller that sequences the fighting-game datapath through its phases: title, fight (vs AI or 2P), round end, match end.
- Drives game_mode, the frame counter count, and a one-cycle round_reset that re-arms both box, health and sprite-ROM instances.
- Sits at top level beside vga_controller. Consumes keyboard keycodes and the two lose flags from the health blocks.
- Replaces the ad-hoc count logic previously kept at top level.

Parameters:
- ROUNDS_TO_WIN, 2, round wins needed to take the match (1..3)
- ROUND_END_FRAMES, 50, frames spent in round-end phase before advancing
- KEY_AI, 8'h1E, USB keycode '1': start a match vs AI
- KEY_2P, 8'h1F, USB keycode '2': start a 2-player match
- KEY_NEXT, 8'h28, USB keycode Enter: leave match-end and return to title
- KEY_RESTART, 8'h15, USB keycode 'R': abort to title from any phase

Ports:
- Clk  in  1  system clock (MAX10_CLK1_50)
- Reset  in  1  synchronous, active-high reset
- frame_clk  in  1  VGA_VS; sampled as data, not used as a clock
- keycodes  in  32  four keycode bytes {k3,k2,k1,k0}
- p1_lose  in  1  player-1 health exhausted
- p2_lose  in  1  player-2 health exhausted
- game_mode  out  3  000 title, 001 vs AI, 010 2P
- phase  out  2  0 TITLE, 1 FIGHT, 2 ROUND_END, 3 MATCH_END
- count  out  9  frames elapsed in current ROUND_END/MATCH_END phase
- round_reset  out  1  one-cycle pulse that re-arms players and health
- p1_rounds  out  2  round wins, player 1
- p2_rounds  out  2  round wins, player 2
- winner  out  2  0 none, 1 P1, 2 P2; valid in MATCH_END

Behaviour:
- Reset (synchronous, active-high):
  - phase=TITLE, game_mode=000, count=0
  - p1_rounds=p2_rounds=0, winner=0, round_reset=0
  - clears the frame synchronizer and key-history registers
- Frame tick:
  - frame_clk passes through a 2-FF synchronizer.
  - frame_tick = synchronized rising edge: exactly one Clk cycle per frame.
- Key press detection:
  - key_hit(K) = K matches any of the 4 bytes this cycle and matched none of them last cycle.
  - Held keys therefore fire once. Keycode 8'h00 never matches.
- KEY_RESTART has priority in every phase:
  - next cycle: phase=TITLE, game_mode=000, rounds/winner/count cleared
  - round_reset pulses 1 cycle
- TITLE:
  - key_hit(KEY_AI) -> game_mode=001, phase=FIGHT, round_reset pulse.
  - key_hit(KEY_2P) -> game_mode=010, same transition.
  - If both are hit in the same cycle, KEY_AI wins.
- FIGHT: lose flags are sampled every Clk.
  - p1_lose & !p2_lose -> p2_rounds+1.
  - p2_lose & !p1_lose -> p1_rounds+1.
  - Both set -> draw: no increment.
  - Any lose flag -> phase=ROUND_END, count=0.
- ROUND_END: count increments on each frame_tick, saturating at ROUND_END_FRAMES.
  - Once count==ROUND_END_FRAMES and either rounds==ROUNDS_TO_WIN -> phase=MATCH_END, count=0, winner set.
  - Otherwise -> phase=FIGHT with a 1-cycle round_reset pulse.
  - Rounds counters saturate at 3 and never wrap.
- MATCH_END:
  - count increments per frame_tick, saturating at 511.
  - key_hit(KEY_NEXT) -> TITLE: game_mode=000, scores and winner cleared, round_reset pulse.
- Phase transitions:
  - game_mode holds its fight value (001/010) through ROUND_END and MATCH_END.
  - It changes only on entry to TITLE or to FIGHT.
- Latency: all outputs are registered and change one Clk after the qualifying input.
- round_reset is never high for two consecutive cycles.
- Lose flags held high across round_reset are ignored for the first frame_tick after FIGHT entry. This blanking window absorbs health-block reset latency.

Decomposition:
- Shared package game_pkg:
  - phase_t enum (TITLE, FIGHT, ROUND_END, MATCH_END)
  - game_mode constants GM_TITLE/GM_AI/GM_2P
  - keycode constants
- Sub-module key_edge:
  - 32-bit keycode compare plus previous-cycle match register
  - one instance per watched keycode, 4 instances

Test Plan:
- Reset, then keycodes=32'h0000001E held 100 cycles -> game_mode=001, phase=FIGHT, exactly one round_reset pulse.
- In FIGHT, p2_lose=1 -> p1_rounds=1, phase=ROUND_END. After 50 frame_clk edges -> phase=FIGHT and round_reset pulses once.
- Second p2_lose with ROUNDS_TO_WIN=2 -> after 50 frames phase=MATCH_END, winner=1. Enter byte in k2 -> TITLE with scores 0.
- p1_lose and p2_lose asserted the same cycle -> both rounds unchanged, ROUND_END entered, then FIGHT resumes.
- keycodes=32'h00001500 pressed during ROUND_END with count=20 -> TITLE next cycle, count=0, game_mode=000.
- Reset asserted mid-MATCH_END with count=300 -> all outputs at reset values on the next Clk.
